// File: rtl/lfsr_arb_pkg.sv
// Shared types, constants and the LFSR step function for lfsr_arbiter.
package lfsr_arb_pkg;

    localparam int unsigned LFSR_W = 32;

    localparam logic [LFSR_W-1:0] POLY_DEFAULT = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 32'h974C_A351;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        SEED = 2'd2,
        WARM = 2'd3
    } arb_state_e;

    // One Galois step: shift right, fold the tap mask in when the lsb falls out set.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] poly);
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module lfsr_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_eff,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh_c,
    output logic [PTR_W-1:0] win_idx_c
);

    always_comb begin
        int unsigned idx;
        logic        found;
        win_oh_c  = '0;
        win_idx_c = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_eff[PTR_W'(idx)]) begin
                found                     = 1'b1;
                win_oh_c[PTR_W'(idx)]     = 1'b1;
                win_idx_c                 = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one 32-bit Galois LFSR, with seed load and warm-up sequencing.
// Optional per-requester grant counters are built when LFSR_ARB_STATS_EN is defined.
module lfsr_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned WARMUP       = 16,
    parameter logic [31:0] SEED_DEFAULT = lfsr_arb_pkg::SEED_DEFAULT,
    parameter logic [31:0] POLY         = lfsr_arb_pkg::POLY_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     seed_we,
    input  logic [31:0]              seed_in,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [31:0]              rnd,
    output logic [7:0]               rnd_lb,
    output logic                     busy
`ifdef LFSR_ARB_STATS_EN
    ,
    input  logic [$clog2(N_REQ)-1:0] stat_sel,
    input  logic                     stat_clr,
    output logic [15:0]              stat_cnt
`endif
);
    import lfsr_arb_pkg::*;

    localparam int unsigned PTR_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 16;

    arb_state_e          state, state_d;
    logic [31:0]         lfsr;
    logic [PTR_W-1:0]    ptr, ptr_nxt, win_idx;
    logic [CNT_W-1:0]    warm_cnt;
    logic [N_REQ-1:0]    req_eff, win_oh, gnt_d;
    logic                arb_go, grant_go, warm_step, busy_d;

    // Requester granted last cycle sits out one cycle.
    assign req_eff = req & ~gnt;
    assign arb_go  = en && (|req_eff);
    assign ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    assign rnd_lb  = rnd[7:0];

    lfsr_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_eff   (req_eff),
        .ptr       (ptr),
        .win_oh_c  (win_oh),
        .win_idx_c (win_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WARM;
        end else begin
            state <= state_d;
        end
    end

    // Seed strobe pre-empts every state, including an active warm-up.
    always_comb begin
        state_d = state;
        if (seed_we) begin
            state_d = SEED;
        end else begin
            case (state)
                IDLE, GNT: state_d = arb_go ? GNT : IDLE;
                SEED:      state_d = WARM;
                WARM:      if (warm_cnt == CNT_W'(1)) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_d     = '0;
        busy_d    = 1'b0;
        warm_step = 1'b0;
        grant_go  = 1'b0;
        warm_step = (state == WARM) && !seed_we;
        grant_go  = (state_d == GNT);
        if (grant_go) begin
            gnt_d = win_oh;
        end
        busy_d = (state_d == SEED) || (state_d == WARM);
    end

    // The LFSR only moves during warm-up or on a grant; rnd keeps the pre-step word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr     <= SEED_DEFAULT;
            gnt      <= '0;
            rnd      <= '0;
            ptr      <= '0;
            warm_cnt <= CNT_W'(WARMUP);
            busy     <= 1'b1;
        end else begin
            gnt  <= gnt_d;
            busy <= busy_d;
            if (seed_we) begin
                lfsr     <= (seed_in == 32'h0) ? SEED_DEFAULT : seed_in;
                warm_cnt <= CNT_W'(WARMUP);
            end else if (warm_step) begin
                lfsr     <= lfsr_step(lfsr, POLY);
                warm_cnt <= warm_cnt - CNT_W'(1);
            end else if (grant_go) begin
                rnd  <= lfsr;
                lfsr <= lfsr_step(lfsr, POLY);
                ptr  <= ptr_nxt;
            end
        end
    end

`ifdef LFSR_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [N_REQ];

    // Saturating grant counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) stat_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (stat_clr) begin
                    stat_q[i] <= '0;
                end else if (gnt_d[i] && (stat_q[i] != {STAT_W{1'b1}})) begin
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter: behavioural model compared every cycle plus literal checks.
module tb_lfsr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned PW = $clog2(N);
    localparam logic [31:0] SEED_DEF = 32'h974CA351;
    localparam logic [31:0] POLY     = 32'h80200003;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0, seed_we = 1'b0;
    logic [31:0]   seed_in = '0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;
    logic [31:0]   rnd;
    logic [7:0]    rnd_lb;
    logic          busy;

    logic          en1 = 1'b0, seed_we1 = 1'b0;
    logic [31:0]   seed_in1 = '0;
    logic [N-1:0]  req1 = '0;
    logic [N-1:0]  gnt1;
    logic [31:0]   rnd1;
    logic [7:0]    rnd_lb1;
    logic          busy1;

    logic [PW-1:0] stat_sel = '0;
    logic          stat_clr = 1'b0;
    logic [15:0]   stat_cnt, stat_cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_arbiter #(.N_REQ(N), .WARMUP(W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .seed_we  (seed_we),
        .seed_in  (seed_in),
        .req      (req),
        .gnt      (gnt),
        .rnd      (rnd),
        .rnd_lb   (rnd_lb),
        .busy     (busy)
`ifdef LFSR_ARB_STATS_EN
        ,
        .stat_sel (stat_sel),
        .stat_clr (stat_clr),
        .stat_cnt (stat_cnt)
`endif
    );

    lfsr_arbiter #(.N_REQ(N), .WARMUP(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en1),
        .seed_we  (seed_we1),
        .seed_in  (seed_in1),
        .req      (req1),
        .gnt      (gnt1),
        .rnd      (rnd1),
        .rnd_lb   (rnd_lb1),
        .busy     (busy1)
`ifdef LFSR_ARB_STATS_EN
        ,
        .stat_sel (stat_sel),
        .stat_clr (1'b0),
        .stat_cnt (stat_cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mstep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    // Model: pending seed cycle, remaining warm steps, then rotating service.
    logic [31:0]  m_lfsr = SEED_DEF;
    logic [31:0]  m_rnd  = '0;
    logic [N-1:0] m_gnt  = '0;
    logic         m_busy = 1'b1;
    bit           m_pend = 1'b0;
    int           m_warm = W;
    int           m_ptr  = 0;
    int           m_stat [N];
    int           mw;
    logic [N-1:0] m_elig, m_ng;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr = SEED_DEF; m_rnd = '0; m_gnt = '0; m_busy = 1'b1;
            m_pend = 1'b0; m_warm = W; m_ptr = 0;
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end else begin
            m_ng = '0;
            if (seed_we) begin
                m_lfsr = (seed_in == 32'h0) ? SEED_DEF : seed_in;
                m_pend = 1'b1;
                m_warm = W;
            end else if (m_pend) begin
                m_pend = 1'b0;
            end else if (m_warm > 0) begin
                m_lfsr = mstep(m_lfsr);
                m_warm--;
            end else if (en) begin
                m_elig = req & ~m_gnt;
                mw = -1;
                for (int k = 0; k < N; k++)
                    if (mw < 0 && m_elig[(m_ptr + k) % N]) mw = (m_ptr + k) % N;
                if (mw >= 0) begin
                    m_ng[mw] = 1'b1;
                    m_rnd    = m_lfsr;
                    m_lfsr   = mstep(m_lfsr);
                    m_ptr    = (mw + 1) % N;
                    if (m_stat[mw] < 65535) m_stat[mw]++;
                end
            end
            if (stat_clr) for (int i = 0; i < N; i++) m_stat[i] = 0;
            m_gnt  = m_ng;
            m_busy = m_pend || (m_warm > 0);
        end
    end

    always @(negedge clk) begin
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rnd", rnd, m_rnd);
        chk("rnd_lb", 32'(rnd_lb), 32'(m_rnd[7:0]));
`ifdef LFSR_ARB_STATS_EN
        chk("stat_cnt", 32'(stat_cnt), 32'(m_stat[stat_sel]));
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == '0 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] r0, r1;
        logic [N-1:0] rot_exp [8];
        rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rnd", rnd, 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);

        // Warm-up length and first grant after reset.
        rst = 1'b1; req = 4'b0001; en = 1'b1;
        count_busy(cnt);
        chk("warm_len", 32'(cnt), 32'd16);
        wait_gnt(cnt);
        chk("first_lat", 32'(cnt), 32'd1);
        chk("first_gnt", 32'(gnt), 32'h1);
        r0 = m_rnd;
        step();
        chk("alt_gap", 32'(gnt), 32'h0);
        step();
        chk("alt_again", 32'(gnt), 32'h1);
        r1 = m_rnd;

        // Full rotation with all requesters active.
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rotate", 32'(gnt), 32'(rot_exp[i]));
        end

        // Seed load in the middle of the stream.
        seed_we = 1'b1; seed_in = $urandom | 32'h1;
        step();
        seed_we = 1'b0;
        chk("seed_gnt0", 32'(gnt), 32'h0);
        count_busy(cnt);
        chk("seed_busy_len", 32'(cnt), 32'(1 + W));
        step();
        chk("resume_ptr", 32'(gnt), 32'b0010);

        // Zero seed falls back to the default seed sequence.
        req = '0; seed_we = 1'b1; seed_in = 32'h0;
        step();
        seed_we = 1'b0;
        count_busy(cnt);
        req = 4'b0001;
        wait_gnt(cnt);
        chk("seed0_rnd0", rnd, r0);
        step();
        step();
        chk("seed0_gnt", 32'(gnt), 32'h1);
        chk("seed0_rnd1", rnd, r1);
        req = '0;

        // Known sequence from seed 1 with a one-step warm-up.
        seed_we1 = 1'b1; seed_in1 = 32'h1;
        step();
        seed_we1 = 1'b0; req1 = 4'b0001; en1 = 1'b1;
        chk("d1_busy", 32'(busy1), 32'h1);
        cnt = 0;
        while (gnt1 == '0 && cnt < 20) begin
            step();
            cnt++;
        end
        chk("d1_gnt", 32'(gnt1), 32'h1);
        chk("d1_rnd0", rnd1, 32'h80200003);
        chk("d1_lb0", 32'(rnd_lb1), 32'h03);
        step();
        chk("d1_gap", 32'(gnt1), 32'h0);
        step();
        chk("d1_rnd1", rnd1, 32'hC0300002);
        req1 = '0; en1 = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            req      = N'($urandom);
            en       = ($urandom % 8) != 0;
            seed_we  = ($urandom % 60) == 0;
            seed_in  = (($urandom % 4) == 0) ? 32'h0 : $urandom;
            stat_clr = ($urandom % 100) == 0;
            stat_sel = PW'($urandom % N);
            step();
        end

        // Asynchronous reset while a grant is visible.
        req = 4'b1111; en = 1'b1; seed_we = 1'b0; stat_clr = 1'b0;
        wait_gnt(cnt);
        chk("pre_rst_gnt", 32'(gnt != '0), 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_rnd", rnd, 32'h0);
        chk("arst_busy", 32'(busy), 32'h1);
`ifdef LFSR_ARB_STATS_EN
        for (int s = 0; s < N; s++) begin
            stat_sel = PW'(s);
            step();
            chk("arst_stat", 32'(stat_cnt), 32'h0);
            chk("arst_stat1", 32'(stat_cnt1), 32'h0);
        end
`endif
        step();
        rst = 1'b1;
        count_busy(cnt);
        chk("rewarm_len", 32'(cnt), 32'd16);
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_arbiter.md
Name: lfsr_arbiter

Overview:
- Shares one 32-bit Galois LFSR among N_REQ requesters using round-robin request/grant.
- Each grant delivers one fresh 32-bit word plus its low byte, then advances the LFSR one step.
- Also sequences seeding: seed load, zero-seed guard, warm-up stepping before service.
- Sits between the random-number core and its consumers (test-pattern, scrambler, backoff units).

Parameters:
N_REQ, 4, number of requesters (2..8)
WARMUP, 16, LFSR steps discarded after reset or seed load (1..255)
SEED_DEFAULT, 32'h974CA351, seed used at reset and when a zero seed is written
POLY, 32'h80200003, Galois tap mask (x^32+x^22+x^2+x+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  arbitration enable; warm-up runs regardless
seed_we  in  1  one-cycle seed load strobe
seed_in  in  32  seed value, sampled with seed_we
req  in  N_REQ  level requests, bit i = requester i
gnt  out  N_REQ  registered one-hot grant, one-cycle pulse
rnd  out  32  word for current grant, valid only while gnt!=0
rnd_lb  out  8  rnd[7:0]
busy  out  1  high in SEED or WARM state

Behaviour:
- LFSR step: lsb=1 -> state=(state>>1)^POLY; else state>>1.
- Reset (rst=0, async): lfsr=SEED_DEFAULT; gnt=0; rnd=0; rr pointer=0; warm counter=WARMUP; FSM=WARM; busy=1.
- FSM states:
  - IDLE, no grant: en & |req_eff -> GNT; seed_we -> SEED.
  - GNT, grant driven: seed_we -> SEED; else en & |req_eff -> GNT; else IDLE.
  - SEED: always -> WARM.
  - WARM: counter 0 -> IDLE.
- seed_we has priority over arbitration in every state, including WARM, where it restarts the warm-up.
- SEED: lfsr=(seed_in==0 ? SEED_DEFAULT : seed_in); counter=WARMUP; gnt=0.
- WARM:
  - LFSR steps every cycle; counter decrements.
  - Leaves after exactly WARMUP steps.
  - gnt=0; requests held pending; busy=1.
- Arbitration:
  - req_eff = req & ~gnt. A requester granted last cycle is masked, so a lone continuous requester is granted every other cycle.
  - Winner = first set bit of req_eff at or above the rr pointer, wrapping modulo N_REQ.
  - Winner is registered to gnt at the next edge. Latency is req-high to gnt one cycle, with no competing winner.
  - On that edge: rnd<=lfsr (pre-step value); LFSR steps once; pointer <= winner+1 mod N_REQ.
- rnd holds its last value when gnt=0.
- en=0: no new grants; a grant already registered completes. The LFSR does not step outside WARM or grants.
- Requesters deassert req after seeing gnt. A still-high req re-arbitrates after the one-cycle mask.
- Reset mid-grant or mid-warm-up: immediate return to the reset state; no partial grant is visible.

Optional Feature:
- Macro LFSR_ARB_STATS_EN.
- Defined:
  - Adds inputs stat_sel [$clog2(N_REQ)] and stat_clr (1).
  - Adds output stat_cnt (16) = grant count of the selected requester.
  - One counter per requester, saturating at 16'hFFFF.
  - Cleared by reset or by stat_clr, which wins over a same-cycle increment.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lfsr_arb_pkg holds:
  - FSM state enum {IDLE, GNT, SEED, WARM};
  - POLY_DEFAULT and SEED_DEFAULT constants;
  - the lfsr_step function.
- One sub-module, lfsr_rr_pick: combinational round-robin picker (req_eff, pointer -> one-hot winner).
- The LFSR register and FSM stay in lfsr_arbiter.

Test Plan:
- Reset, then req=4'b0001 held, en=1:
  - busy=1 and gnt=0 for exactly 16 cycles after reset release.
  - Then gnt=0001 with rnd equal to SEED_DEFAULT stepped 16 times.
  - Grants repeat every other cycle.
- seed_we with seed_in=32'h00000001 and WARMUP=1 (override), then req=0001:
  - First grant rnd=32'h80200003, rnd_lb=8'h03.
  - Next grant rnd=32'hC0300002.
- seed_in=0:
  - lfsr loads 32'h974CA351, not zero; the output sequence matches the reset sequence.
- req=4'b1111 held:
  - Grants rotate 0001,0010,0100,1000,0001 on consecutive cycles, with no gaps.
- seed_we asserted during a grant stream:
  - gnt=0 the next cycle; busy=1 for 1+WARMUP cycles.
  - Rotation resumes from the saved pointer.
- rst pulsed low mid-stream:
  - gnt=0 and rnd=0 immediately (asynchronous).
  - Full warm-up repeats.
  - With LFSR_ARB_STATS_EN, all stat_cnt read 0.
